// File: rtl/qix_shared_ram_arbiter_if.sv
// rtl/qix_shared_ram_arbiter_if.sv - CPU port A/B and RAM-side signals of the shared RAM arbiter
// slave: the arbiter itself; master: the CPU boards plus the RAM.
interface qix_shared_ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic [DW-1:0] a_dout;
  logic          a_ack;
  logic          a_ovr;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic [DW-1:0] b_dout;
  logic          b_ack;
  logic          b_ovr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din, mem_dout,
    output a_dout, a_ack, a_ovr, b_dout, b_ack, b_ovr, mem_addr, mem_din, mem_we
  );

  modport master (
    output a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din, mem_dout,
    input  a_dout, a_ack, a_ovr, b_dout, b_ack, b_ovr, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/qix_shared_ram_arbiter.sv
// rtl/qix_shared_ram_arbiter.sv - one-access-per-cycle arbiter sharing a single-port RAM
// between the data CPU (port A) and the video CPU (port B).
module qix_shared_ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int RR = 1
) (
  input logic                     clk_20m,
  input logic                     reset,
  qix_shared_ram_arbiter_if.slave bus
);
  logic          r_a_pend, r_a_we;
  logic [AW-1:0] r_a_addr;
  logic [DW-1:0] r_a_din;
  logic          r_b_pend, r_b_we;
  logic [AW-1:0] r_b_addr;
  logic [DW-1:0] r_b_din;
  logic          r_ptr;
  logic          r_s1_vld, r_s1_port, r_s1_we;
  logic          r_a_ack, r_a_ovr, r_b_ack, r_b_ovr;
  logic [DW-1:0] r_a_dout, r_b_dout;
  logic [AW-1:0] r_mem_addr;

  logic          w_a_iss, w_b_iss, w_a_acc, w_b_acc;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_din;
  logic          w_mem_we;

  // r_ptr = 0 names port A; only consulted when both ports are pending.
  assign w_a_iss = !reset && r_a_pend && (!r_b_pend || (RR == 0) || !r_ptr);
  assign w_b_iss = !reset && r_b_pend && (!r_a_pend || ((RR != 0) && r_ptr));
  assign w_a_acc = !r_a_pend || w_a_iss;
  assign w_b_acc = !r_b_pend || w_b_iss;

  always_comb begin
    w_mem_addr = r_mem_addr;
    w_mem_din  = r_a_din;
    w_mem_we   = 1'b0;
    if (w_a_iss) begin
      w_mem_addr = r_a_addr;
      w_mem_din  = r_a_din;
      w_mem_we   = r_a_we;
    end else if (w_b_iss) begin
      w_mem_addr = r_b_addr;
      w_mem_din  = r_b_din;
      w_mem_we   = r_b_we;
    end
  end

  always_ff @(posedge clk_20m) begin
    if (reset) begin
      r_a_pend   <= 1'b0;
      r_b_pend   <= 1'b0;
      r_ptr      <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_port  <= 1'b0;
      r_s1_we    <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_ovr    <= 1'b0;
      r_b_ovr    <= 1'b0;
      r_a_dout   <= '0;
      r_b_dout   <= '0;
      r_mem_addr <= '0;
    end else begin
      if (bus.a_req && w_a_acc) begin
        r_a_pend <= 1'b1;
        r_a_we   <= bus.a_we;
        r_a_addr <= bus.a_addr;
        r_a_din  <= bus.a_din;
      end else if (w_a_iss) begin
        r_a_pend <= 1'b0;
      end
      if (bus.b_req && w_b_acc) begin
        r_b_pend <= 1'b1;
        r_b_we   <= bus.b_we;
        r_b_addr <= bus.b_addr;
        r_b_din  <= bus.b_din;
      end else if (w_b_iss) begin
        r_b_pend <= 1'b0;
      end
      r_a_ovr <= bus.a_req && !w_a_acc;
      r_b_ovr <= bus.b_req && !w_b_acc;

      if ((RR != 0) && r_a_pend && r_b_pend)
        r_ptr <= ~r_ptr;
      if (w_a_iss || w_b_iss)
        r_mem_addr <= w_mem_addr;

      // Stage 1 covers the RAM's registered read; completion lands one cycle later.
      r_s1_vld  <= w_a_iss || w_b_iss;
      r_s1_port <= w_b_iss;
      r_s1_we   <= w_mem_we;
      r_a_ack   <= r_s1_vld && !r_s1_port;
      r_b_ack   <= r_s1_vld && r_s1_port;
      if (r_s1_vld && !r_s1_port && !r_s1_we)
        r_a_dout <= bus.mem_dout;
      if (r_s1_vld && r_s1_port && !r_s1_we)
        r_b_dout <= bus.mem_dout;
    end
  end

  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_din  = w_mem_din;
  assign bus.mem_we   = w_mem_we;
  assign bus.a_dout   = r_a_dout;
  assign bus.a_ack    = r_a_ack;
  assign bus.a_ovr    = r_a_ovr;
  assign bus.b_dout   = r_b_dout;
  assign bus.b_ack    = r_b_ack;
  assign bus.b_ovr    = r_b_ovr;
endmodule

// File: tb/tb_qix_shared_ram_arbiter.sv
// tb/tb_qix_shared_ram_arbiter.sv - directed bench for the shared RAM arbiter
// u1 runs round-robin (RR=1), u0 runs port-A fixed priority (RR=0).
module tb_qix_shared_ram_arbiter;
  logic clk_20m = 1'b0;
  logic reset;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk_20m = ~clk_20m;

  qix_shared_ram_arbiter_if #(.AW(10), .DW(8)) bus1 ();
  qix_shared_ram_arbiter_if #(.AW(10), .DW(8)) bus0 ();

  qix_shared_ram_arbiter #(.AW(10), .DW(8), .RR(1)) u1 (
    .clk_20m (clk_20m),
    .reset   (reset),
    .bus     (bus1)
  );

  qix_shared_ram_arbiter #(.AW(10), .DW(8), .RR(0)) u0 (
    .clk_20m (clk_20m),
    .reset   (reset),
    .bus     (bus0)
  );

  logic [7:0] ram1 [0:1023];
  logic [7:0] ram1_q;
  logic [7:0] ram0 [0:1023];
  logic [7:0] ram0_q;

  always_ff @(posedge clk_20m) begin
    if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_din;
    ram1_q <= ram1[bus1.mem_addr];
    if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_din;
    ram0_q <= ram0[bus0.mem_addr];
  end
  assign bus1.mem_dout = ram1_q;
  assign bus0.mem_dout = ram0_q;

  task automatic tick();
    @(posedge clk_20m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_a1(input logic we, input logic [9:0] addr, input logic [7:0] din);
    bus1.a_req = 1'b1; bus1.a_we = we; bus1.a_addr = addr; bus1.a_din = din;
  endtask

  task automatic req_b1(input logic we, input logic [9:0] addr, input logic [7:0] din);
    bus1.b_req = 1'b1; bus1.b_we = we; bus1.b_addr = addr; bus1.b_din = din;
  endtask

  task automatic write_a1(input logic [9:0] addr, input logic [7:0] din);
    req_a1(1'b1, addr, din);
    tick();
    bus1.a_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_din = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_din = 0;
    bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0; bus0.a_din = 0;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0; bus0.b_din = 0;
    repeat (3) tick();
    chk("rst_a_ack", bus1.a_ack, 0);
    chk("rst_b_ack", bus1.b_ack, 0);
    chk("rst_a_ovr", bus1.a_ovr, 0);
    chk("rst_a_dout", bus1.a_dout, 0);
    chk("rst_b_dout", bus1.b_dout, 0);
    chk("rst_mem_we", bus1.mem_we, 0);
    reset = 1'b0;
    tick();

    // preload write, also checks write issue and write ack
    req_a1(1'b1, 10'h155, 8'h3C);
    tick();
    bus1.a_req = 1'b0;
    chk("wr_mem_we", bus1.mem_we, 1);
    chk("wr_mem_addr", bus1.mem_addr, 10'h155);
    chk("wr_mem_din", bus1.mem_din, 8'h3C);
    tick();
    tick();
    chk("wr_a_ack", bus1.a_ack, 1);
    chk("wr_a_dout_kept", bus1.a_dout, 0);
    tick();
    write_a1(10'h010, 8'h11);
    write_a1(10'h020, 8'h22);

    // uncontended read, 3-cycle latency
    req_a1(1'b0, 10'h155, 8'h00);
    tick();
    bus1.a_req = 1'b0;
    chk("t1_mem_addr", bus1.mem_addr, 10'h155);
    chk("t1_mem_we", bus1.mem_we, 0);
    tick();
    chk("t1_ack_c2", bus1.a_ack, 0);
    tick();
    chk("t1_ack_c3", bus1.a_ack, 1);
    chk("t1_dout", bus1.a_dout, 8'h3C);
    chk("t1_b_ack", bus1.b_ack, 0);
    tick();
    chk("t1_ack_c4", bus1.a_ack, 0);

    // round-robin: pointer starts at A
    req_a1(1'b0, 10'h010, 8'h00);
    req_b1(1'b0, 10'h020, 8'h00);
    tick();
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    chk("t2a_iss1", bus1.mem_addr, 10'h010);
    tick();
    chk("t2a_iss2", bus1.mem_addr, 10'h020);
    tick();
    chk("t2a_a_ack", bus1.a_ack, 1);
    chk("t2a_b_ack_c3", bus1.b_ack, 0);
    chk("t2a_a_dout", bus1.a_dout, 8'h11);
    tick();
    chk("t2a_b_ack", bus1.b_ack, 1);
    chk("t2a_a_ack_c4", bus1.a_ack, 0);
    chk("t2a_b_dout", bus1.b_dout, 8'h22);
    tick();
    req_a1(1'b0, 10'h010, 8'h00);
    req_b1(1'b0, 10'h020, 8'h00);
    tick();
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    chk("t2b_iss1", bus1.mem_addr, 10'h020);
    tick();
    chk("t2b_iss2", bus1.mem_addr, 10'h010);
    tick();
    chk("t2b_b_ack", bus1.b_ack, 1);
    chk("t2b_a_ack_c3", bus1.a_ack, 0);
    tick();
    chk("t2b_a_ack", bus1.a_ack, 1);
    tick();

    // fixed priority instance: A first every time
    for (int i = 0; i < 3; i++) begin
      bus0.a_req = 1'b1; bus0.a_addr = 10'h030;
      bus0.b_req = 1'b1; bus0.b_addr = 10'h040;
      tick();
      bus0.a_req = 1'b0; bus0.b_req = 1'b0;
      chk("t3_iss1", bus0.mem_addr, 10'h030);
      tick();
      chk("t3_iss2", bus0.mem_addr, 10'h040);
      tick();
      chk("t3_a_ack", bus0.a_ack, 1);
      tick();
      chk("t3_b_ack", bus0.b_ack, 1);
      tick();
    end

    // same-address write collision, pointer back at A
    req_a1(1'b1, 10'h100, 8'hAA);
    req_b1(1'b1, 10'h100, 8'h55);
    tick();
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    chk("t4_din1", bus1.mem_din, 8'hAA);
    tick();
    chk("t4_din2", bus1.mem_din, 8'h55);
    tick();
    chk("t4_a_ack", bus1.a_ack, 1);
    tick();
    chk("t4_b_ack", bus1.b_ack, 1);
    tick();
    req_a1(1'b0, 10'h100, 8'h00);
    tick();
    bus1.a_req = 1'b0;
    tick();
    tick();
    chk("t4_rd_ack", bus1.a_ack, 1);
    chk("t4_rd_data", bus1.a_dout, 8'h55);
    tick();

    // overrun: pointer now at B, A re-requests while still pending
    req_a1(1'b0, 10'h155, 8'h00);
    req_b1(1'b0, 10'h020, 8'h00);
    tick();
    bus1.b_req = 1'b0;
    bus1.a_addr = 10'h010;
    chk("t5_b_first", bus1.mem_addr, 10'h020);
    tick();
    bus1.a_req = 1'b0;
    chk("t5_ovr", bus1.a_ovr, 1);
    chk("t5_a_iss", bus1.mem_addr, 10'h155);
    tick();
    chk("t5_ovr_c3", bus1.a_ovr, 0);
    chk("t5_b_ack", bus1.b_ack, 1);
    chk("t5_a_ack_c3", bus1.a_ack, 0);
    tick();
    chk("t5_a_ack", bus1.a_ack, 1);
    chk("t5_a_dout", bus1.a_dout, 8'h3C);
    tick();
    chk("t5_a_ack_c5", bus1.a_ack, 0);
    tick();
    chk("t5_a_ack_c6", bus1.a_ack, 0);

    // reset discards an in-flight access
    req_b1(1'b0, 10'h020, 8'h00);
    tick();
    bus1.b_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_b_ack_c2", bus1.b_ack, 0);
    chk("t6_b_dout", bus1.b_dout, 0);
    chk("t6_a_dout", bus1.a_dout, 0);
    req_a1(1'b0, 10'h155, 8'h00);
    tick();
    bus1.a_req = 1'b0;
    chk("t6_b_ack_c3", bus1.b_ack, 0);
    chk("t6_mem_addr", bus1.mem_addr, 10'h155);
    tick();
    chk("t6_b_ack_c4", bus1.b_ack, 0);
    chk("t6_a_ack_early", bus1.a_ack, 0);
    tick();
    chk("t6_a_ack", bus1.a_ack, 1);
    chk("t6_a_dout_post", bus1.a_dout, 8'h3C);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
